pal_sync_generator_multi: RTL
=============================

// Module: pal_sync_generator_multi
// PURPOSE
//  Multi-mode PAL timing generator for the Spectrum core: 48K / 128K / Pentagon raster counters,
//  registered blank, hsync, vsync and csync, ULA-style frame interrupt, and RGB blanking of CW-bit channels.
//  Sits between the ULA pixel path and the video output encoder/scandoubler.
//  Mode switches are deferred to the frame boundary, so the raster never tears.
// PARAMETERS
//  CW        3    colour bits per channel
//  H_END_M0  447  last hcnt, mode 0 (48K)
//  V_END_M0  311  last vcnt, mode 0
//  H_END_M1  455  last hcnt, mode 1 (128K)
//  V_END_M1  310  last vcnt, mode 1
//  H_END_M2  447  last hcnt, mode 2 (Pentagon)
//  V_END_M2  319  last vcnt, mode 2
//  HBLANK_B / HBLANK_E  320 / 415  horizontal blank window, inclusive
//  HSYNC_B / HSYNC_E    344 / 375  horizontal sync window, inclusive
//  VBLANK_B / VBLANK_E  248 / 255  vertical blank window, inclusive
//  VSYNC_B / VSYNC_E    248 / 251  vertical sync window, inclusive
//  INT_LINE  248  line on which int_n asserts
//  INT_LEN   32   int_n low width in clk cycles; must be <= every H_END
// PORTS
//  clk          in   1     pixel clock
//  rst          in   1     synchronous reset, active high
//  mode         in   2     requested timing: 0=48K, 1=128K, 2=Pentagon, 3=treated as 0
//  rgb_i        in   3*CW  {r,g,b} pixel from ULA
//  hcnt         out  9     horizontal counter (register)
//  vcnt         out  9     vertical counter (register)
//  mode_active  out  2     mode currently in force (after 3->0 mapping)
//  rgb_o        out  3*CW  blanked {r,g,b}
//  blank        out  1     1 = inside H or V blank window
//  hsync_n      out  1     low inside HSYNC window
//  vsync_n      out  1     low inside VSYNC lines
//  csync        out  1     composite sync, active low
//  int_n        out  1     frame interrupt, active low
//  frame_start  out  1     1-cycle pulse at raster (0,0)
// BEHAVIOUR
//  - Reset, any cycle: hcnt=0, vcnt=0, mode_active=map(mode), rgb_o=0, blank=1,
//    hsync_n=1, vsync_n=1, csync=1, int_n=1, frame_start=0. Reset overrides everything.
//  - Counter: if hcnt==H_END(mode_active), then hcnt<=0 and vcnt<=(vcnt==V_END ? 0 : vcnt+1).
//    Otherwise hcnt<=hcnt+1. Use 9-bit arithmetic; counters never exceed the active END.
//  - Mode latch: mode is sampled only on the cycle where hcnt==H_END and vcnt==V_END (frame wrap).
//    The new ends apply from (0,0). Mid-frame changes of mode are ignored until that point.
//  - Outputs are registered decodes of the current hcnt/vcnt/rgb_i. Every output lags its counter
//    value by exactly 1 clk. Example: counter (320,x) gives blank=1 on the following clk.
//  - blank = H window OR V window. While blank=1, rgb_o=0; otherwise rgb_o=rgb_i.
//  - csync = 0 when blank AND (hcnt in HSYNC OR vcnt in VSYNC); otherwise 1.
//    Optional feature below modifies this.
//  - int_n = 0 when vcnt==INT_LINE AND hcnt<INT_LEN: once per frame, INT_LEN clks wide.
//  - frame_start = 1 when hcnt==0 AND vcnt==0.
// CONFIGURATION
//  PAL_SYNC_SERRATION_EN defined:
//    - On VSYNC lines, csync = 1 while hcnt in HSYNC window and 0 for the rest of the line
//      (inverted-hsync serration, so PLL monitors hold lock).
//    - hsync_n and vsync_n are unchanged.
//  Not defined:
//    - csync stays 0 for the whole of every VSYNC line.
// TESTING
//  1. rst, then mode=0, run 2 frames -> frame_start period 448*312=139776 clks; hcnt 447->0; vcnt 311->0.
//  2. mode 0->1 at vcnt=100 -> mode_active stays 0 until wrap at (447,311), then 1;
//     next frame period 456*311=141816.
//  3. mode=3 after rst -> mode_active=0; timing identical to scenario 1.
//  4. Any mode -> int_n low for exactly 32 clks, starting 1 clk after counter (0,248); once per frame.
//  5. rgb_i all ones, mode 0 -> rgb_o=0 for counter hcnt 320..415 (+1 clk lag); csync low for 344..375;
//     on vcnt 248..251 csync low all line (macro off) or high only on 344..375 (macro on).
//  6. rst pulsed 1 clk at counter (200,150) -> next clk hcnt=0, vcnt=0, all outputs at reset values;
//     frame_start pulse follows on the clk after.

Source files
------------

// File: rtl/pal_sync_generator_multi.sv
// Multi-mode PAL raster timing (48K / 128K / Pentagon) with registered sync, blank, interrupt and RGB blanking.
// Optional: define PAL_SYNC_SERRATION_EN for inverted-hsync serration of csync on vsync lines.
module pal_sync_generator_multi #(
    parameter int unsigned CW       = 3,
    parameter int unsigned H_END_M0 = 447,
    parameter int unsigned V_END_M0 = 311,
    parameter int unsigned H_END_M1 = 455,
    parameter int unsigned V_END_M1 = 310,
    parameter int unsigned H_END_M2 = 447,
    parameter int unsigned V_END_M2 = 319,
    parameter int unsigned HBLANK_B = 320,
    parameter int unsigned HBLANK_E = 415,
    parameter int unsigned HSYNC_B  = 344,
    parameter int unsigned HSYNC_E  = 375,
    parameter int unsigned VBLANK_B = 248,
    parameter int unsigned VBLANK_E = 255,
    parameter int unsigned VSYNC_B  = 248,
    parameter int unsigned VSYNC_E  = 251,
    parameter int unsigned INT_LINE = 248,
    parameter int unsigned INT_LEN  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [3*CW-1:0]   rgb_i,
    output logic [8:0]        hcnt,
    output logic [8:0]        vcnt,
    output logic [1:0]        mode_active,
    output logic [3*CW-1:0]   rgb_o,
    output logic              blank,
    output logic              hsync_n,
    output logic              vsync_n,
    output logic              csync,
    output logic              int_n,
    output logic              frame_start
);

    localparam int unsigned CNT_W = 9;
    localparam int unsigned RGB_W = 3 * CW;

    typedef logic [CNT_W-1:0] cnt_t;

    // Mode 3 is not a real machine; it runs 48K timing.
    function automatic logic [1:0] map_mode(input logic [1:0] m);
        return (m == 2'd3) ? 2'd0 : m;
    endfunction

    function automatic logic in_win(input cnt_t c, input cnt_t b, input cnt_t e);
        return (c >= b) && (c <= e);
    endfunction

    cnt_t             hcnt_q, hcnt_d;
    cnt_t             vcnt_q, vcnt_d;
    logic [1:0]       mode_active_q, mode_active_d;
    logic [RGB_W-1:0] rgb_o_q, rgb_o_d;
    logic             blank_q, blank_d;
    logic             hsync_n_q, hsync_n_d;
    logic             vsync_n_q, vsync_n_d;
    logic             csync_q, csync_d;
    logic             int_n_q, int_n_d;
    logic             frame_start_q, frame_start_d;

    cnt_t h_end, v_end;
    logic in_hb, in_vb, in_hs, in_vs;

    // Raster extents of the mode currently in force.
    always_comb begin
        h_end = CNT_W'(H_END_M0);
        v_end = CNT_W'(V_END_M0);
        case (mode_active_q)
            2'd1: begin
                h_end = CNT_W'(H_END_M1);
                v_end = CNT_W'(V_END_M1);
            end
            2'd2: begin
                h_end = CNT_W'(H_END_M2);
                v_end = CNT_W'(V_END_M2);
            end
            default: ;
        endcase
    end

    always_comb begin
        hcnt_d        = hcnt_q + CNT_W'(1);
        vcnt_d        = vcnt_q;
        mode_active_d = mode_active_q;

        // Mode is only picked up at the frame wrap so a frame never mixes timings.
        if (hcnt_q == h_end) begin
            hcnt_d = '0;
            if (vcnt_q == v_end) begin
                vcnt_d        = '0;
                mode_active_d = map_mode(mode);
            end else begin
                vcnt_d = vcnt_q + CNT_W'(1);
            end
        end

        in_hb = in_win(hcnt_q, CNT_W'(HBLANK_B), CNT_W'(HBLANK_E));
        in_vb = in_win(vcnt_q, CNT_W'(VBLANK_B), CNT_W'(VBLANK_E));
        in_hs = in_win(hcnt_q, CNT_W'(HSYNC_B), CNT_W'(HSYNC_E));
        in_vs = in_win(vcnt_q, CNT_W'(VSYNC_B), CNT_W'(VSYNC_E));

        blank_d   = in_hb | in_vb;
        rgb_o_d   = blank_d ? '0 : rgb_i;
        hsync_n_d = ~in_hs;
        vsync_n_d = ~in_vs;
`ifdef PAL_SYNC_SERRATION_EN
        // Serrated vsync: csync pulses high where hsync would be low.
        if (blank_d & in_vs) begin
            csync_d = in_hs;
        end else begin
            csync_d = ~(blank_d & in_hs);
        end
`else
        csync_d = ~(blank_d & (in_hs | in_vs));
`endif
        int_n_d       = ~((vcnt_q == CNT_W'(INT_LINE)) && (hcnt_q < CNT_W'(INT_LEN)));
        frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            mode_active_q <= map_mode(mode);
            rgb_o_q       <= '0;
            blank_q       <= 1'b1;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            csync_q       <= 1'b1;
            int_n_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            mode_active_q <= mode_active_d;
            rgb_o_q       <= rgb_o_d;
            blank_q       <= blank_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            csync_q       <= csync_d;
            int_n_q       <= int_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign mode_active = mode_active_q;
    assign rgb_o       = rgb_o_q;
    assign blank       = blank_q;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign csync       = csync_q;
    assign int_n       = int_n_q;
    assign frame_start = frame_start_q;

endmodule
